adc_burst_sched: RTL and testbench

Scheduler that sequences ADC capture into framed bursts for the modem datapath. On `start_i` it runs `PKT_NUM` packets, each consisting of a discarded guard gap of `GAP_LEN` ADC samples followed by a forwarded burst of `BURST_LEN` samples. Bursts go onto a valid/ready stream with `last` framing. It sits between the ADC sample interface (125 MHz domain) and the demodulator input, and reports progress, completion and overrun to the control logic.

---
 rtl/adc_burst_sched.sv | 154 +++++++++++++++
 tb/tb_adc_burst_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_burst_sched.sv
// ADC burst scheduler: discards a guard gap, then forwards a framed burst, PKT_NUM times per run.
// Optional build macro ADC_BURST_SCHED_OFFSET_BIN_EN converts offset-binary samples to two's complement.
module adc_burst_sched #(
  parameter int unsigned ADC_WIDTH = 14,
  parameter int unsigned BURST_LEN = 500,
  parameter int unsigned GAP_LEN   = 16,
  parameter int unsigned PKT_NUM   = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [ADC_WIDTH-1:0]         adc_data_i,
  input  logic                         adc_valid_i,
  output logic [ADC_WIDTH-1:0]         m_data_o,
  output logic                         m_valid_o,
  output logic                         m_last_o,
  input  logic                         m_ready_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [$clog2(PKT_NUM+1)-1:0] pkt_cnt_o,
  output logic                         overrun_o
);

  localparam int unsigned MaxLen = (BURST_LEN > GAP_LEN) ? BURST_LEN : GAP_LEN;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);
  localparam int unsigned PcW    = $clog2(PKT_NUM + 1);

  localparam logic [CntW-1:0] BurstLast = CntW'(BURST_LEN - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [PcW-1:0]  PktLast   = PcW'(PKT_NUM - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGap   = 2'd1;
  localparam logic [1:0] StBurst = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;
  // With no guard gap, every packet starts directly in BURST.
  localparam logic [1:0] StFirst = (GAP_LEN > 0) ? StGap : StBurst;

  logic [1:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [PcW-1:0]       pkt_q, pkt_d;
  logic                 ovr_q, ovr_d;
  logic                 vld_q, vld_d;
  logic                 last_q, last_d;
  logic [ADC_WIDTH-1:0] data_q, data_d;
  logic [ADC_WIDTH-1:0] sample;

`ifdef ADC_BURST_SCHED_OFFSET_BIN_EN
  localparam logic [ADC_WIDTH-1:0] MsbMask = ADC_WIDTH'(1) << (ADC_WIDTH - 1);
  assign sample = adc_data_i ^ MsbMask;
`else
  assign sample = adc_data_i;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    ovr_d   = ovr_q;
    vld_d   = vld_q;
    last_d  = last_q;
    data_d  = data_q;

    if (vld_q && m_ready_i) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_d   = '0;
          pkt_d   = '0;
          ovr_d   = 1'b0;
          state_d = StFirst;
        end
      end
      StGap: begin
        if (adc_valid_i) begin
          if (cnt_q == GapLast) begin
            cnt_d   = '0;
            state_d = StBurst;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StBurst: begin
        if (adc_valid_i) begin
          // A dropped sample still counts toward the burst length.
          if (!vld_q || m_ready_i) begin
            vld_d  = 1'b1;
            data_d = sample;
            last_d = (cnt_q == BurstLast);
          end else begin
            ovr_d = 1'b1;
          end
          if (cnt_q == BurstLast) begin
            cnt_d   = '0;
            pkt_d   = pkt_q + 1'b1;
            state_d = (pkt_q == PktLast) ? StDone : StFirst;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (!vld_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a simultaneous start.
    if (abort_i) begin
      state_d = StIdle;
      cnt_d   = cnt_q;
      pkt_d   = pkt_q;
      ovr_d   = ovr_q;
      vld_d   = 1'b0;
      last_d  = 1'b0;
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pkt_q   <= '0;
      ovr_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      ovr_q   <= ovr_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign m_data_o  = data_q;
  assign m_valid_o = vld_q;
  assign m_last_o  = last_q;
  assign busy_o    = (state_q == StGap) || (state_q == StBurst);
  assign done_o    = (state_q == StDone) && !vld_q && !abort_i;
  assign pkt_cnt_o = pkt_q;
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_adc_burst_sched.sv
// Directed bench for adc_burst_sched: nominal run, backpressure drop, abort, illegal start,
// reset mid-gap, and a GAP_LEN=0 instance with sparse valid.
module tb_adc_burst_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  // Instance A: default parameters.
  logic        a_start, a_abort, a_valid, a_ready;
  logic [13:0] a_data, a_mdata;
  logic        a_mvalid, a_mlast, a_busy, a_done, a_ovr;
  logic [3:0]  a_pkt;

  adc_burst_sched u_dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (a_start),
    .abort_i    (a_abort),
    .adc_data_i (a_data),
    .adc_valid_i(a_valid),
    .m_data_o   (a_mdata),
    .m_valid_o  (a_mvalid),
    .m_last_o   (a_mlast),
    .m_ready_i  (a_ready),
    .busy_o     (a_busy),
    .done_o     (a_done),
    .pkt_cnt_o  (a_pkt),
    .overrun_o  (a_ovr)
  );

  // Instance B: no guard gap, short bursts.
  logic        b_start, b_abort, b_valid, b_ready;
  logic [13:0] b_data, b_mdata;
  logic        b_mvalid, b_mlast, b_busy, b_done, b_ovr;
  logic [1:0]  b_pkt;

  adc_burst_sched #(
    .ADC_WIDTH(14),
    .BURST_LEN(4),
    .GAP_LEN  (0),
    .PKT_NUM  (2)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .start_i    (b_start),
    .abort_i    (b_abort),
    .adc_data_i (b_data),
    .adc_valid_i(b_valid),
    .m_data_o   (b_mdata),
    .m_valid_o  (b_mvalid),
    .m_last_o   (b_mlast),
    .m_ready_i  (b_ready),
    .busy_o     (b_busy),
    .done_o     (b_done),
    .pkt_cnt_o  (b_pkt),
    .overrun_o  (b_ovr)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Stream monitor for instance A: per-burst delivered length, first/last data, done pulses.
  logic        mon_clr;
  int          nb, cur, done_seen;
  int          lens [16];
  logic [13:0] first_d [16];
  logic [13:0] last_d [16];

  always @(posedge clk) begin
    if (mon_clr) begin
      nb        <= 0;
      cur       <= 0;
      done_seen <= 0;
    end else begin
      if (a_done) done_seen <= done_seen + 1;
      if (a_mvalid && a_ready) begin
        if (cur == 0 && nb < 16) first_d[nb[3:0]] <= a_mdata;
        if (a_mlast) begin
          if (nb < 16) begin
            lens[nb[3:0]]   <= cur + 1;
            last_d[nb[3:0]] <= a_mdata;
          end
          nb  <= nb + 1;
          cur <= 0;
        end else begin
          cur <= cur + 1;
        end
      end
    end
  end

  function automatic logic [13:0] ex(input logic [13:0] v);
`ifdef ADC_BURST_SCHED_OFFSET_BIN_EN
    return v ^ 14'h2000;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    a_data = a_data + 14'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mvalid"}, a_mvalid, 0);
    chk({tag, "_mlast"},  a_mlast,  0);
    chk({tag, "_mdata"},  a_mdata,  0);
    chk({tag, "_busy"},   a_busy,   0);
    chk({tag, "_done"},   a_done,   0);
    chk({tag, "_pkt"},    a_pkt,    0);
    chk({tag, "_ovr"},    a_ovr,    0);
  endtask

  task automatic run_to_done(input string tag);
    for (int i = 0; i < 6000 && done_seen == 0; i++) tick();
    chk({tag, "_done_pulse"}, done_seen, 1);
  endtask

  logic [13:0] b_samp [8];

  initial begin
    a_start = 0; a_abort = 0; a_valid = 0; a_ready = 1; a_data = '0;
    b_start = 0; b_abort = 0; b_valid = 0; b_ready = 1; b_data = '0;
    mon_clr = 1;
    b_samp = '{14'h2000, 14'h0000, 14'h0101, 14'h0102, 14'h3fff, 14'h1234, 14'h0001, 14'h2abc};

    // Reset values.
    tick();
    tick();
    chk_reset("rst");
    chk("rst_b_busy", b_busy, 0);
    rst = 0;
    tick();

    // Nominal run: 10 x (16 gap + 500 burst), valid every cycle, ready high.
    mon_clr = 0;
    a_valid = 1;
    a_data  = 14'd100;
    a_start = 1;
    tick();
    a_start = 0;
    chk("nom_busy_after_start", a_busy, 1);
    chk("nom_start_sample_ignored", a_mvalid, 0);
    repeat (16) tick();
    chk("nom_gap_discarded", a_mvalid, 0);
    tick();
    chk("nom_first_valid", a_mvalid, 1);
    chk("nom_first_data", a_mdata, ex(14'd117));
    chk("nom_first_last", a_mlast, 0);
    run_to_done("nom");
    tick();
    chk("nom_idle_busy", a_busy, 0);
    chk("nom_done_single", done_seen, 1);
    chk("nom_bursts", nb, 10);
    chk("nom_len0", lens[0], 500);
    chk("nom_len9", lens[9], 500);
    chk("nom_first0", first_d[0], ex(14'd117));
    chk("nom_last0", last_d[0], ex(14'd616));
    chk("nom_first9", first_d[9], ex(14'd4761));
    chk("nom_last9", last_d[9], ex(14'd5260));
    chk("nom_pkt", a_pkt, 10);
    chk("nom_ovr", a_ovr, 0);

    // Backpressure: ready low for 3 cycles, valid low in the first of them -> 2 drops.
    mon_clr = 1;
    tick();
    mon_clr = 0;
    a_data  = 14'd100;
    a_start = 1;
    tick();
    a_start = 0;
    repeat (26) tick();
    chk("bp_pre_data", a_mdata, ex(14'd126));
    a_ready = 0;
    a_valid = 0;
    tick();
    chk("bp_hold1_data", a_mdata, ex(14'd126));
    chk("bp_hold1_valid", a_mvalid, 1);
    chk("bp_hold1_ovr", a_ovr, 0);
    a_valid = 1;
    tick();
    chk("bp_hold2_data", a_mdata, ex(14'd126));
    chk("bp_hold2_ovr", a_ovr, 1);
    tick();
    chk("bp_hold3_data", a_mdata, ex(14'd126));
    a_ready = 1;
    tick();
    chk("bp_resume_data", a_mdata, ex(14'd130));
    chk("bp_resume_valid", a_mvalid, 1);
    run_to_done("bp");
    tick();
    chk("bp_bursts", nb, 10);
    chk("bp_len0", lens[0], 498);
    chk("bp_last0", last_d[0], ex(14'd617));
    chk("bp_len1", lens[1], 500);
    chk("bp_ovr_sticky", a_ovr, 1);
    chk("bp_pkt", a_pkt, 10);

    // Abort at burst sample 250 of packet 3.
    mon_clr = 1;
    tick();
    mon_clr = 0;
    a_data  = 14'd100;
    a_start = 1;
    tick();
    a_start = 0;
    chk("ab_start_ovr_clr", a_ovr, 0);
    chk("ab_start_pkt_clr", a_pkt, 0);
    repeat (1297) tick();
    a_abort = 1;
    tick();
    a_abort = 0;
    chk("ab_mvalid", a_mvalid, 0);
    chk("ab_busy", a_busy, 0);
    chk("ab_pkt", a_pkt, 2);
    chk("ab_done", a_done, 0);
    repeat (3) tick();
    chk("ab_no_done", done_seen, 0);
    chk("ab_pkt_hold", a_pkt, 2);

    // Abort and start together: abort wins.
    a_start = 1;
    a_abort = 1;
    tick();
    a_abort = 0;
    chk("ab_start_busy", a_busy, 0);
    chk("ab_start_pkt", a_pkt, 2);
    a_data = 14'd100;
    tick();
    a_start = 0;
    chk("restart_pkt", a_pkt, 0);
    chk("restart_busy", a_busy, 1);

    // Start during BURST is ignored.
    repeat (17) tick();
    a_start = 1;
    tick();
    a_start = 0;
    chk("ill_start_valid", a_mvalid, 1);
    chk("ill_start_data", a_mdata, ex(14'd118));
    tick();
    chk("ill_start_next_valid", a_mvalid, 1);
    chk("ill_start_next_data", a_mdata, ex(14'd119));
    repeat (497) tick();
    chk("pk1_pkt", a_pkt, 1);
    chk("pk1_last", a_mlast, 1);
    chk("pk1_data", a_mdata, ex(14'd616));

    // Last sample held into GAP, then reset mid-GAP.
    a_ready = 0;
    tick();
    chk("gap_hold_valid", a_mvalid, 1);
    chk("gap_hold_last", a_mlast, 1);
    chk("gap_busy", a_busy, 1);
    rst = 1;
    tick();
    chk_reset("rst_mid");
    rst     = 0;
    a_ready = 1;
    a_valid = 0;
    tick();

    // Instance B: GAP_LEN=0, valid every 4th cycle.
    b_start = 1;
    tick();
    b_start = 0;
    chk("b_busy_start", b_busy, 1);
    chk("b_mvalid_start", b_mvalid, 0);
    for (int k = 0; k < 8; k++) begin
      b_valid = 1;
      b_data  = b_samp[k];
      tick();
      b_valid = 0;
      chk("b_valid", b_mvalid, 1);
      chk("b_data", b_mdata, ex(b_samp[k]));
      chk("b_last", b_mlast, (k % 4) == 3);
      chk("b_pkt", b_pkt, (k + 1) / 4);
      chk("b_busy", b_busy, k != 7);
      if (k < 7) begin
        for (int j = 0; j < 3; j++) begin
          tick();
          chk("b_idle_gap", b_mvalid, 0);
        end
      end
    end
    chk("b_done_wait", b_done, 0);
    tick();
    chk("b_done_pulse", b_done, 1);
    chk("b_drained", b_mvalid, 0);
    tick();
    chk("b_done_end", b_done, 0);
    chk("b_busy_end", b_busy, 0);
    chk("b_pkt_end", b_pkt, 2);
    chk("b_ovr_end", b_ovr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
